// File: rtl/inst_fetch_queue_pkg.sv
// Shared opcodes, FSM states and queue entry layout for inst_fetch_queue.
// The return-address stack is built only when IFQ_RAS_EN is defined.
package inst_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef enum logic [1:0] {
        StFetch,
        StWaitMem,
        StDrain
    } ifq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred_pc;
        logic            pred_taken;
    } ifq_entry_t;

    // x1 (ra) and x5 (t0) are the link registers of the calling convention.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ifq_predecode.sv
// Combinational predecode of a fetched instruction: control-flow class,
// J/B immediates and call/return hints for the return-address stack.
module ifq_predecode
    import inst_fetch_queue_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            is_branch,
    output logic [XLEN-1:0] imm_j,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] pc_plus4,
    output logic            is_link,
    output logic            is_ret
);

    assign is_jal    = (inst[6:0] == OP_JAL);
    assign is_jalr   = (inst[6:0] == OP_JALR);
    assign is_branch = (inst[6:0] == OP_BRANCH);

    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    assign pc_plus4 = pc + 32'd4;

    // Call pushes a return address; plain return (rd=x0) pops one.
    assign is_link = (is_jal || is_jalr) && is_link_reg(inst[11:7]);
    assign is_ret  = is_jalr && is_link_reg(inst[19:15]) && (inst[11:7] == 5'd0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: icache lookup, miss handling with flush-safe drain,
// predecode/next-PC prediction and a circular FIFO toward dispatch.
// Define IFQ_RAS_EN to add a return-address stack for JAL/JALR prediction.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BHT_IDX_W = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [31:0]             flush_pc,
    output logic [31:0]             icache_addr,
    input  logic                    icache_hit,
    input  logic [31:0]             icache_inst,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_inst,
    output logic                    fill_en,
    output logic [31:0]             fill_addr,
    output logic [31:0]             fill_inst,
    output logic [BHT_IDX_W-1:0]    bht_index,
    input  logic                    bht_taken,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [31:0]             deq_inst,
    output logic [31:0]             deq_pc,
    output logic [31:0]             deq_pred_pc,
    output logic                    deq_pred_taken,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch_queue: DEPTH must be a power of two >= 2");
    end
    if (RAS_DEPTH < 2) begin : g_bad_ras_depth
        $error("inst_fetch_queue: RAS_DEPTH must be >= 2");
    end

    ifq_state_e       state;
    logic [31:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    ifq_entry_t       fifo [DEPTH];
    ifq_entry_t       head_entry;

    logic        can_fetch;
    logic        do_enq;
    logic        do_deq;
    logic [31:0] enq_inst;
    logic [31:0] pred_pc;
    logic        pred_taken;

    logic        is_jal, is_jalr, is_branch, is_link, is_ret;
    logic [31:0] imm_j, imm_b, pc_plus4;

    ifq_predecode u_predecode (
        .inst      (enq_inst),
        .pc        (pc),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_branch (is_branch),
        .imm_j     (imm_j),
        .imm_b     (imm_b),
        .pc_plus4  (pc_plus4),
        .is_link   (is_link),
        .is_ret    (is_ret)
    );

    assign can_fetch = (state == StFetch) && (count != CNT_W'(DEPTH));
    assign enq_inst  = (state == StWaitMem) ? mem_inst : icache_inst;
    assign fill_en   = rdy && !flush && (state == StWaitMem) && mem_ready;
    assign do_enq    = rdy && !flush && ((can_fetch && icache_hit) || fill_en);
    assign do_deq    = rdy && !flush && deq_valid && deq_ready;

`ifdef IFQ_RAS_EN
    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]          ras_stack [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_top;
    logic [RAS_PTR_W-1:0] ras_top_inc;
    logic [RAS_PTR_W-1:0] ras_top_dec;
    logic [RAS_CNT_W-1:0] ras_cnt;
    logic                 ras_pop_ok;

    // ras_top is the next free slot; a full stack overwrites its oldest entry.
    assign ras_top_inc = (ras_top == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_top + RAS_PTR_W'(1);
    assign ras_top_dec = (ras_top == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : ras_top - RAS_PTR_W'(1);
    assign ras_pop_ok  = is_ret && (ras_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (rdy) begin
            if (flush) begin
                ras_top <= '0;
                ras_cnt <= '0;
            end else if (do_enq && is_link) begin
                ras_top <= ras_top_inc;
                if (ras_cnt != RAS_CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + RAS_CNT_W'(1);
            end else if (do_enq && ras_pop_ok) begin
                ras_top <= ras_top_dec;
                ras_cnt <= ras_cnt - RAS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq && is_link) ras_stack[ras_top] <= pc_plus4;
    end
`else
    logic unused_ras;
    assign unused_ras = ^{is_link, is_ret};
`endif

    always_comb begin
        pred_pc    = pc_plus4;
        pred_taken = 1'b0;
        if (is_jal) begin
            pred_pc    = pc + imm_j;
            pred_taken = 1'b1;
        end else if (is_branch && bht_taken) begin
            pred_pc    = pc + imm_b;
            pred_taken = 1'b1;
        end else if (is_jalr) begin
`ifdef IFQ_RAS_EN
            if (ras_pop_ok) begin
                pred_pc    = ras_stack[ras_top_dec];
                pred_taken = 1'b1;
            end
`else
            pred_pc    = pc_plus4;
            pred_taken = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StFetch;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= flush_pc;
                // An outstanding miss must still be absorbed before fetching again.
                if (state != StFetch) begin
                    if (mem_ready) begin
                        state   <= StFetch;
                        mem_req <= 1'b0;
                    end else begin
                        state <= StDrain;
                    end
                end
            end else begin
                if (do_enq) begin
                    tail <= tail + PTR_W'(1);
                    pc   <= pred_pc;
                end
                if (do_deq) head <= head + PTR_W'(1);
                if (do_enq && !do_deq) count <= count + CNT_W'(1);
                if (!do_enq && do_deq) count <= count - CNT_W'(1);

                unique case (state)
                    StFetch: begin
                        if (can_fetch && !icache_hit) begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            state    <= StWaitMem;
                        end
                    end
                    StWaitMem, StDrain: begin
                        if (mem_ready) begin
                            mem_req <= 1'b0;
                            state   <= StFetch;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            fifo[tail] <= '{inst: enq_inst, pc: pc, pred_pc: pred_pc, pred_taken: pred_taken};
        end
    end

    assign head_entry     = fifo[head];
    assign deq_valid      = (count != '0);
    assign deq_inst       = deq_valid ? head_entry.inst : '0;
    assign deq_pc         = deq_valid ? head_entry.pc : '0;
    assign deq_pred_pc    = deq_valid ? head_entry.pred_pc : '0;
    assign deq_pred_taken = deq_valid && head_entry.pred_taken;

    assign icache_addr = can_fetch ? pc : '0;
    assign bht_index   = pc[BHT_IDX_W+1:2];
    assign fill_addr   = fill_en ? pc : '0;
    assign fill_inst   = fill_en ? mem_inst : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue-based
// reference model; honours IFQ_RAS_EN for the return-stack predictions.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BHT_IDX_W = 8;
    localparam int unsigned RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush, icache_hit, mem_ready, bht_taken, deq_ready;
    logic [31:0] flush_pc, icache_inst, mem_inst;
    logic [31:0] icache_addr, mem_addr, fill_addr, fill_inst;
    logic [31:0] deq_inst, deq_pc, deq_pred_pc;
    logic        mem_req, fill_en, deq_valid, deq_pred_taken;
    logic [BHT_IDX_W-1:0]    bht_index;
    logic [$clog2(DEPTH):0]  count;

    int errors = 0;
    int checks = 0;

    inst_fetch_queue #(
        .DEPTH     (DEPTH),
        .BHT_IDX_W (BHT_IDX_W),
        .RESET_PC  (32'h0),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .icache_addr    (icache_addr),
        .icache_hit     (icache_hit),
        .icache_inst    (icache_inst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_inst       (mem_inst),
        .fill_en        (fill_en),
        .fill_addr      (fill_addr),
        .fill_inst      (fill_inst),
        .bht_index      (bht_index),
        .bht_taken      (bht_taken),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_inst       (deq_inst),
        .deq_pc         (deq_pc),
        .deq_pred_pc    (deq_pred_pc),
        .deq_pred_taken (deq_pred_taken),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        tk;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    logic [31:0] m_mem_addr;
    bit          m_miss;
    bit          m_drain;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ras.delete();
        m_pc       = 32'h0;
        m_mem_addr = 32'h0;
        m_miss     = 0;
        m_drain    = 0;
    endtask

    task automatic model_enqueue(input logic [31:0] ins);
        logic [6:0]         opc;
        logic [4:0]         rd, rs1;
        logic signed [20:0] ij;
        logic signed [12:0] ib;
        logic [31:0]        nxt;
        logic               tk;
        opc = ins[6:0];
        rd  = ins[11:7];
        rs1 = ins[19:15];
        ij  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ib  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt = m_pc + 32'd4;
        tk  = 1'b0;
        if (opc == 7'h6f) begin
            nxt = m_pc + 32'(ij);
            tk  = 1'b1;
        end else if (opc == 7'h63 && bht_taken) begin
            nxt = m_pc + 32'(ib);
            tk  = 1'b1;
        end
`ifdef IFQ_RAS_EN
        if (opc == 7'h67 && (rs1 == 5'd1 || rs1 == 5'd5) && rd == 5'd0 && m_ras.size() > 0) begin
            nxt = m_ras.pop_back();
            tk  = 1'b1;
        end
        if ((opc == 7'h6f || opc == 7'h67) && (rd == 5'd1 || rd == 5'd5)) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
`endif
        m_q.push_back('{inst: ins, pc: m_pc, pred_pc: nxt, tk: tk});
        m_pc = nxt;
    endtask

    task automatic model_update();
        bit deq_fire;
        if (!rdy) return;
        if (flush) begin
            m_q.delete();
            m_ras.delete();
            m_pc = flush_pc;
            if (m_miss) begin
                m_miss  = 0;
                m_drain = !mem_ready;
            end else if (m_drain && mem_ready) begin
                m_drain = 0;
            end
            return;
        end
        deq_fire = (m_q.size() != 0) && deq_ready;
        if (m_miss) begin
            if (mem_ready) begin
                if (deq_fire) void'(m_q.pop_front());
                model_enqueue(mem_inst);
                m_miss = 0;
                return;
            end
        end else if (m_drain) begin
            if (mem_ready) m_drain = 0;
        end else if (m_q.size() < DEPTH) begin
            if (icache_hit) begin
                if (deq_fire) void'(m_q.pop_front());
                model_enqueue(icache_inst);
                return;
            end
            m_miss     = 1;
            m_mem_addr = m_pc;
        end
        if (deq_fire) void'(m_q.pop_front());
    endtask

    task automatic cmp_model();
        bit can, fe;
        can = !m_miss && !m_drain && (m_q.size() < DEPTH);
        fe  = rdy && !flush && m_miss && mem_ready;
        check_val("icache_addr", icache_addr, can ? m_pc : 32'h0);
        check_val("mem_req", 32'(mem_req), 32'(m_miss || m_drain));
        check_val("mem_addr", mem_addr, m_mem_addr);
        check_val("fill_en", 32'(fill_en), 32'(fe));
        check_val("fill_addr", fill_addr, fe ? m_pc : 32'h0);
        check_val("fill_inst", fill_inst, fe ? mem_inst : 32'h0);
        check_val("bht_index", 32'(bht_index), 32'(m_pc[BHT_IDX_W+1:2]));
        check_val("count", 32'(count), m_q.size());
        check_val("deq_valid", 32'(deq_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("deq_inst", deq_inst, m_q[0].inst);
            check_val("deq_pc", deq_pc, m_q[0].pc);
            check_val("deq_pred_pc", deq_pred_pc, m_q[0].pred_pc);
            check_val("deq_pred_taken", 32'(deq_pred_taken), 32'(m_q[0].tk));
        end
    endtask

    task automatic tick();
        #1;
        cmp_model();
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic hit, input logic [31:0] inst, input logic bht,
                          input logic dr, input logic mr, input logic fl, input logic [31:0] fpc);
        rdy         = 1'b1;
        icache_hit  = hit;
        icache_inst = inst;
        mem_inst    = inst;
        bht_taken   = bht;
        deq_ready   = dr;
        mem_ready   = mr;
        flush       = fl;
        flush_pc    = fpc;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 4))
            0:       r[6:0] = 7'h13;
            1:       r[6:0] = 7'h6f;
            2:       r[6:0] = 7'h63;
            default: r[6:0] = 7'h67;
        endcase
        r[11:7]  = pick_reg();
        r[19:15] = pick_reg();
        return r;
    endfunction

    task automatic rand_inputs();
        rdy         = ($urandom_range(0, 9) != 0);
        flush       = ($urandom_range(0, 24) == 0);
        flush_pc    = $urandom() & 32'hffff_fffc;
        icache_hit  = ($urandom_range(0, 9) < 7);
        icache_inst = gen_inst();
        mem_inst    = gen_inst();
        bht_taken   = 1'($urandom_range(0, 1));
        deq_ready   = 1'($urandom_range(0, 1));
        mem_ready   = (m_miss || m_drain) && ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rdy = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_deq_valid", 32'(deq_valid), 32'h0);
        check_val("rst_mem_req", 32'(mem_req), 32'h0);
        check_val("rst_icache_addr", icache_addr, 32'h0);
        cmp_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Three sequential hits, then simultaneous enqueue/dequeue.
        repeat (3) begin
            set_in(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check_val("seq_count", 32'(count), 32'd3);
        check_val("seq_pc0", deq_pc, 32'h0);
        check_val("seq_pred0", deq_pred_pc, 32'h4);
        set_in(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("seq_pc1", deq_pc, 32'h4);
        check_val("seq_pred1", deq_pred_pc, 32'h8);
        check_val("seq_count_same", 32'(count), 32'd3);
        tick();
        check_val("seq_pc2", deq_pc, 32'h8);
        check_val("seq_pred2", deq_pred_pc, 32'hc);

        // Miss at 0x100 served after five request cycles.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("miss_req", 32'(mem_req), 32'h1);
        check_val("miss_addr", mem_addr, 32'h100);
        repeat (4) tick();
        set_in(1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check_val("miss_fill_en", 32'(fill_en), 32'h1);
        check_val("miss_fill_addr", fill_addr, 32'h100);
        tick();
        check_val("miss_req_done", 32'(mem_req), 32'h0);
        check_val("miss_count", 32'(count), 32'd1);
        check_val("miss_next_pc", icache_addr, 32'h104);

        // JAL +0x20 at 0x40, BEQ -8 at 0x60 taken and not taken.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        set_in(1'b1, 32'h0200_006f, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("jal_pred", deq_pred_pc, 32'h60);
        check_val("jal_taken", 32'(deq_pred_taken), 32'h1);
        check_val("jal_redirect", icache_addr, 32'h60);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60);
        tick();
        set_in(1'b1, 32'hfe00_0ce3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("beq_t_pred", deq_pred_pc, 32'h58);
        check_val("beq_t_taken", 32'(deq_pred_taken), 32'h1);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60);
        tick();
        set_in(1'b1, 32'hfe00_0ce3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("beq_nt_pred", deq_pred_pc, 32'h64);
        check_val("beq_nt_taken", 32'(deq_pred_taken), 32'h0);

        // Fill to DEPTH, then one dequeue lets fetch resume with tail wrapped.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        repeat (DEPTH) begin
            set_in(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check_val("full_count", 32'(count), DEPTH);
        set_in(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check_val("full_no_lookup", icache_addr, 32'h0);
        tick();
        check_val("full_count_deq", 32'(count), DEPTH - 1);
        check_val("full_resume", icache_addr, 32'h40);
        set_in(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("full_again", 32'(count), DEPTH);
        repeat (20) begin
            set_in(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end

        // Flush during a miss: the late response is drained, not filled.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        check_val("drain_req", 32'(mem_req), 32'h1);
        check_val("drain_no_lookup", icache_addr, 32'h0);
        set_in(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        set_in(1'b0, 32'h1234_5013, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check_val("drain_no_fill", 32'(fill_en), 32'h0);
        tick();
        check_val("drain_lookup", icache_addr, 32'h200);
        check_val("drain_count", 32'(count), 32'h0);

        // rdy low freezes everything, even with handshakes offered.
        repeat (2) begin
            set_in(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        set_in(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        rdy = 1'b0;
        repeat (4) tick();
        check_val("frz_count", 32'(count), 32'd2);
        check_val("frz_pc", icache_addr, 32'h208);
        check_val("frz_head", deq_pc, 32'h200);

        // Call then return: prediction from the return stack when enabled.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        set_in(1'b1, 32'h0200_00ef, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b1, 32'h0000_8067, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("ret_pc", deq_pc, 32'ha0);
`ifdef IFQ_RAS_EN
        check_val("ret_pred", deq_pred_pc, 32'h84);
        check_val("ret_taken", 32'(deq_pred_taken), 32'h1);
`else
        check_val("ret_pred", deq_pred_pc, 32'ha4);
        check_val("ret_taken", 32'(deq_pred_taken), 32'h0);
`endif

        // Asynchronous reset in the middle of a miss.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_mem_req", 32'(mem_req), 32'h0);
        check_val("arst_icache_addr", icache_addr, 32'h0);
        check_val("arst_count", 32'(count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
